// File: rtl/ysyx_22040175_bus_arbiter_if.sv
// Memory-side req/gnt/rvalid bus shared by the IF and LSU requesters.
// master = arbiter side, slave = memory side.
interface ysyx_22040175_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                mem_req;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_wmask;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ysyx_22040175_bus_arbiter.sv
// IF/LSU arbiter for one req/gnt/rvalid memory port, with pipeline stalls.
// Define ARB_TIMEOUT_EN to enable the response watchdog and bus_err.
module ysyx_22040175_bus_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 64,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                flush,
    output logic [31:0]         if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_valid,
    output logic                lsu_stall,
    output logic                bus_err,
    ysyx_22040175_bus_arbiter_if.master mem
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t state, state_n;
    logic owner, last_owner, drop;
    logic if_cand, lsu_cand;
    logic grant, grant_lsu, done, tmo, limit;
    logic [DATA_W-1:0] rsp;

    assign if_stall  = if_req & ~if_valid;
    assign lsu_stall = lsu_req & ~lsu_valid;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign limit = (cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(TIMEOUT), ERR_DATA};
    assign limit = 1'b0;
`endif

    // The requester whose valid is pulsing still shows its old request.
    always_comb begin
        if_cand   = if_req & ~flush & ~if_valid;
        lsu_cand  = lsu_req & ~lsu_valid;
        grant     = 1'b0;
        grant_lsu = 1'b0;
        done      = 1'b0;
        state_n   = state;
        unique case (state)
            IDLE: begin
                if (if_cand | lsu_cand) begin
                    grant     = 1'b1;
                    grant_lsu = lsu_cand &
                                ~(if_cand & (last_owner == OWN_LSU));
                    state_n   = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (mem.mem_gnt) begin
                    done    = mem.mem_rvalid;
                    state_n = mem.mem_rvalid ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem.mem_rvalid) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        tmo = (state != IDLE) & ~done & limit;
        if (tmo) begin
            state_n = IDLE;
        end
        rsp = tmo ? ERR_DATA : mem.mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner         <= OWN_IF;
            last_owner    <= OWN_IF;
            drop          <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_wmask <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            if_rdata      <= '0;
            if_valid      <= 1'b0;
            lsu_rdata     <= '0;
            lsu_valid     <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            lsu_valid <= 1'b0;
            bus_err   <= tmo;
            if (grant) begin
                owner         <= grant_lsu;
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= grant_lsu & lsu_we;
                mem.mem_wmask <= grant_lsu ? lsu_wmask : '0;
                mem.mem_addr  <= grant_lsu ? lsu_addr : if_addr;
                mem.mem_wdata <= grant_lsu ? lsu_wdata : '0;
                drop          <= 1'b0;
            end
            if ((state == WAIT_GNT && mem.mem_gnt) || tmo) begin
                mem.mem_req <= 1'b0;
            end
            if (done | tmo) begin
                last_owner <= owner;
                drop       <= 1'b0;
                if (owner == OWN_LSU) begin
                    lsu_valid <= 1'b1;
                    lsu_rdata <= rsp;
                end else if (!(drop | flush)) begin
                    if_valid <= 1'b1;
                    if_rdata <= rsp[31:0];
                end
            end else if (state != IDLE && owner == OWN_IF && flush) begin
                drop <= 1'b1;
            end
        end
    end
endmodule
